// File: rtl/multicycle_ctrl_alu_if.sv
// Bus between the multicycle control/ALU slice and the datapath around it.
// The ILLEGAL_OPCODE_EN macro adds the illegal_instruction flag.
interface multicycle_ctrl_alu_if;
    logic [31:0] instruction;
    logic [31:0] alu_in_a;
    logic [31:0] alu_in_b;
    logic [31:0] alu_result;
    logic        zero;
    logic        pc_write;
    logic        pc_write_cond;
    logic        pc_load;
    logic        pc_source;
    logic        lorD;
    logic        memory_read;
    logic        memory_write;
    logic        memory_to_reg;
    logic        ir_write;
    logic        reg_write;
    logic [1:0]  alu_src_a;
    logic [1:0]  alu_src_b;
`ifdef ILLEGAL_OPCODE_EN
    logic        illegal_instruction;
`endif

    modport master (
`ifdef ILLEGAL_OPCODE_EN
        input  illegal_instruction,
`endif
        output instruction, alu_in_a, alu_in_b,
        input  alu_result, zero, pc_write, pc_write_cond, pc_load, pc_source,
               lorD, memory_read, memory_write, memory_to_reg, ir_write,
               reg_write, alu_src_a, alu_src_b
    );

    modport slave (
`ifdef ILLEGAL_OPCODE_EN
        output illegal_instruction,
`endif
        input  instruction, alu_in_a, alu_in_b,
        output alu_result, zero, pc_write, pc_write_cond, pc_load, pc_source,
               lorD, memory_read, memory_write, memory_to_reg, ir_write,
               reg_write, alu_src_a, alu_src_b
    );
endinterface

// File: rtl/multicycle_ctrl_alu.sv
// Multicycle RV32I control FSM, ALU-op decoder and 32-bit ALU.
// Optional macro ILLEGAL_OPCODE_EN: unknown opcodes halt and raise illegal_instruction.
module multicycle_ctrl_alu (
    input  logic                  clk,
    input  logic                  reset,
    multicycle_ctrl_alu_if.slave  bus
);
    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_EXEC_R    = 4'd2,
        S_EXEC_I    = 4'd3,
        S_ALU_WB    = 4'd4,
        S_MEM_ADDR  = 4'd5,
        S_MEM_READ  = 4'd6,
        S_MEM_WB    = 4'd7,
        S_MEM_WRITE = 4'd8,
        S_BRANCH    = 4'd9,
        S_JAL       = 4'd10,
        S_JALR      = 4'd11,
        S_LINK      = 4'd12,
        S_LUI       = 4'd13,
        S_AUIPC     = 4'd14,
        S_HALT      = 4'd15
    } state_t;

    localparam logic [3:0] OP_AND      = 4'b0000;
    localparam logic [3:0] OP_OR       = 4'b0001;
    localparam logic [3:0] OP_ADD      = 4'b0010;
    localparam logic [3:0] OP_XOR      = 4'b0100;
    localparam logic [3:0] OP_SLL      = 4'b0101;
    localparam logic [3:0] OP_SRL      = 4'b0110;
    localparam logic [3:0] OP_SRA      = 4'b0111;
    localparam logic [3:0] OP_SLT      = 4'b1000;
    localparam logic [3:0] OP_SLTU     = 4'b1001;
    localparam logic [3:0] OP_SUB      = 4'b1010;
    localparam logic [3:0] OP_SEQ      = 4'b1011;
    localparam logic [3:0] OP_SGE      = 4'b1100;
    localparam logic [3:0] OP_SGEU     = 4'b1101;
    localparam logic [3:0] OP_ADD_CLR0 = 4'b1110;

    state_t      state_q, state_d;
    logic [3:0]  alu_op;
    logic        pc_write_raw, pc_write_cond_raw, ir_write_raw, reg_write_raw;
    logic        memory_read_raw, memory_write_raw;
    logic [6:0]  opcode;
    logic [2:0]  func3;
    logic        func7_b5;
    logic [31:0] result;
    logic        unused_instr_bits;

    assign opcode   = bus.instruction[6:0];
    assign func3    = bus.instruction[14:12];
    assign func7_b5 = bus.instruction[30];
    assign unused_instr_bits = ^{bus.instruction[31], bus.instruction[29:15], bus.instruction[11:7]};

    function automatic logic [3:0] func_op(input logic [2:0] f3, input logic f7b5, input logic is_imm);
        case (f3)
            3'b000:  func_op = (!is_imm && f7b5) ? OP_SUB : OP_ADD;
            3'b001:  func_op = OP_SLL;
            3'b010:  func_op = OP_SLT;
            3'b011:  func_op = OP_SLTU;
            3'b100:  func_op = OP_XOR;
            3'b101:  func_op = f7b5 ? OP_SRA : OP_SRL;
            3'b110:  func_op = OP_OR;
            default: func_op = OP_AND;
        endcase
    endfunction

    // Each branch picks the op whose result is zero exactly when the branch is taken.
    function automatic logic [3:0] branch_op(input logic [2:0] f3);
        case (f3)
            3'b001:  branch_op = OP_SEQ;
            3'b100:  branch_op = OP_SGE;
            3'b101:  branch_op = OP_SLT;
            3'b110:  branch_op = OP_SGEU;
            3'b111:  branch_op = OP_SLTU;
            default: branch_op = OP_SUB;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d           = state_q;
        alu_op            = OP_AND;
        pc_write_raw      = 1'b0;
        pc_write_cond_raw = 1'b0;
        ir_write_raw      = 1'b0;
        reg_write_raw     = 1'b0;
        memory_read_raw   = 1'b0;
        memory_write_raw  = 1'b0;
        bus.pc_source     = 1'b0;
        bus.lorD          = 1'b0;
        bus.memory_to_reg = 1'b0;
        bus.alu_src_a     = 2'b00;
        bus.alu_src_b     = 2'b00;
        case (state_q)
            S_FETCH: begin
                memory_read_raw = 1'b1;
                ir_write_raw    = 1'b1;
                pc_write_raw    = 1'b1;
                bus.alu_src_b   = 2'b01;
                alu_op          = OP_ADD;
                state_d         = S_DECODE;
            end
            S_DECODE: begin
                bus.alu_src_a = 2'b10;
                bus.alu_src_b = 2'b10;
                alu_op        = OP_ADD;
                case (opcode)
                    7'b0110011:             state_d = S_EXEC_R;
                    7'b0010011:             state_d = S_EXEC_I;
                    7'b0000011, 7'b0100011: state_d = S_MEM_ADDR;
                    7'b1100011:             state_d = S_BRANCH;
                    7'b1101111:             state_d = S_JAL;
                    7'b1100111:             state_d = S_JALR;
                    7'b0110111:             state_d = S_LUI;
                    7'b0010111:             state_d = S_AUIPC;
                    7'b0001111, 7'b1110011: state_d = S_FETCH;
`ifdef ILLEGAL_OPCODE_EN
                    default:                state_d = S_HALT;
`else
                    default:                state_d = S_FETCH;
`endif
                endcase
            end
            S_EXEC_R: begin
                bus.alu_src_a = 2'b01;
                alu_op        = func_op(func3, func7_b5, 1'b0);
                state_d       = S_ALU_WB;
            end
            S_EXEC_I: begin
                bus.alu_src_a = 2'b01;
                bus.alu_src_b = 2'b10;
                alu_op        = func_op(func3, func7_b5, 1'b1);
                state_d       = S_ALU_WB;
            end
            S_ALU_WB: begin
                reg_write_raw = 1'b1;
                state_d       = S_FETCH;
            end
            S_MEM_ADDR: begin
                bus.alu_src_a = 2'b01;
                bus.alu_src_b = 2'b10;
                alu_op        = OP_ADD;
                // Stores (0100011) differ from loads (0000011) only in bit 5.
                state_d       = opcode[5] ? S_MEM_WRITE : S_MEM_READ;
            end
            S_MEM_READ: begin
                bus.lorD        = 1'b1;
                memory_read_raw = 1'b1;
                state_d         = S_MEM_WB;
            end
            S_MEM_WB: begin
                reg_write_raw     = 1'b1;
                bus.memory_to_reg = 1'b1;
                state_d           = S_FETCH;
            end
            S_MEM_WRITE: begin
                bus.lorD         = 1'b1;
                memory_write_raw = 1'b1;
                state_d          = S_FETCH;
            end
            S_BRANCH: begin
                bus.alu_src_a     = 2'b01;
                alu_op            = branch_op(func3);
                pc_write_cond_raw = 1'b1;
                bus.pc_source     = 1'b1;
                state_d           = S_FETCH;
            end
            S_JAL: begin
                bus.alu_src_a = 2'b10;
                bus.alu_src_b = 2'b01;
                alu_op        = OP_ADD;
                pc_write_raw  = 1'b1;
                bus.pc_source = 1'b1;
                state_d       = S_ALU_WB;
            end
            S_JALR: begin
                bus.alu_src_a = 2'b01;
                bus.alu_src_b = 2'b10;
                alu_op        = OP_ADD_CLR0;
                pc_write_raw  = 1'b1;
                state_d       = S_LINK;
            end
            S_LINK: begin
                bus.alu_src_a = 2'b10;
                bus.alu_src_b = 2'b01;
                alu_op        = OP_ADD;
                state_d       = S_ALU_WB;
            end
            S_LUI: begin
                bus.alu_src_a = 2'b11;
                bus.alu_src_b = 2'b10;
                alu_op        = OP_ADD;
                state_d       = S_ALU_WB;
            end
            S_AUIPC: begin
                bus.alu_src_a = 2'b10;
                bus.alu_src_b = 2'b10;
                alu_op        = OP_ADD;
                state_d       = S_ALU_WB;
            end
            default: begin
                state_d = S_HALT;
            end
        endcase
    end

    always_comb begin
        result = 32'd0;
        case (alu_op)
            OP_AND:      result = bus.alu_in_a & bus.alu_in_b;
            OP_OR:       result = bus.alu_in_a | bus.alu_in_b;
            OP_ADD:      result = bus.alu_in_a + bus.alu_in_b;
            OP_XOR:      result = bus.alu_in_a ^ bus.alu_in_b;
            OP_SLL:      result = bus.alu_in_a << bus.alu_in_b[4:0];
            OP_SRL:      result = bus.alu_in_a >> bus.alu_in_b[4:0];
            OP_SRA:      result = $unsigned($signed(bus.alu_in_a) >>> bus.alu_in_b[4:0]);
            OP_SLT:      result = {31'd0, $signed(bus.alu_in_a) < $signed(bus.alu_in_b)};
            OP_SLTU:     result = {31'd0, bus.alu_in_a < bus.alu_in_b};
            OP_SUB:      result = bus.alu_in_a - bus.alu_in_b;
            OP_SEQ:      result = {31'd0, bus.alu_in_a == bus.alu_in_b};
            OP_SGE:      result = {31'd0, $signed(bus.alu_in_a) >= $signed(bus.alu_in_b)};
            OP_SGEU:     result = {31'd0, bus.alu_in_a >= bus.alu_in_b};
            OP_ADD_CLR0: result = (bus.alu_in_a + bus.alu_in_b) & 32'hFFFF_FFFE;
            default:     result = 32'd0;
        endcase
    end

    // Write enables and memory strobes are suppressed for as long as reset is held.
    assign bus.pc_write      = pc_write_raw & ~reset;
    assign bus.pc_write_cond = pc_write_cond_raw & ~reset;
    assign bus.ir_write      = ir_write_raw & ~reset;
    assign bus.reg_write     = reg_write_raw & ~reset;
    assign bus.memory_read   = memory_read_raw & ~reset;
    assign bus.memory_write  = memory_write_raw & ~reset;
    assign bus.alu_result    = result;
    assign bus.zero          = (result == 32'd0);
    assign bus.pc_load       = bus.pc_write | (bus.pc_write_cond & bus.zero);
`ifdef ILLEGAL_OPCODE_EN
    assign bus.illegal_instruction = (state_q == S_HALT);
`endif
endmodule

// File: tb/tb_multicycle_ctrl_alu.sv
// Scoreboard bench for multicycle_ctrl_alu: per-cycle expected controls and ALU results.
module tb_multicycle_ctrl_alu;
    logic clk = 1'b0;
    logic reset;
    multicycle_ctrl_alu_if bus ();

    multicycle_ctrl_alu dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    // {pc_write, pc_write_cond, pc_source, lorD, mem_read, mem_write, mem_to_reg, ir_write, reg_write, src_a, src_b}
    localparam logic [12:0] C_FETCH  = 13'b1_0_0_0_1_0_0_1_0_00_01;
    localparam logic [12:0] C_DEC    = 13'b0_0_0_0_0_0_0_0_0_10_10;
    localparam logic [12:0] C_EXR    = 13'b0_0_0_0_0_0_0_0_0_01_00;
    localparam logic [12:0] C_EXI    = 13'b0_0_0_0_0_0_0_0_0_01_10;
    localparam logic [12:0] C_WB     = 13'b0_0_0_0_0_0_0_0_1_00_00;
    localparam logic [12:0] C_MRD    = 13'b0_0_0_1_1_0_0_0_0_00_00;
    localparam logic [12:0] C_MWB    = 13'b0_0_0_0_0_0_1_0_1_00_00;
    localparam logic [12:0] C_MWR    = 13'b0_0_0_1_0_1_0_0_0_00_00;
    localparam logic [12:0] C_BR     = 13'b0_1_1_0_0_0_0_0_0_01_00;
    localparam logic [12:0] C_JAL    = 13'b1_0_1_0_0_0_0_0_0_10_01;
    localparam logic [12:0] C_JALR   = 13'b1_0_0_0_0_0_0_0_0_01_10;
    localparam logic [12:0] C_LINK   = 13'b0_0_0_0_0_0_0_0_0_10_01;
    localparam logic [12:0] C_LUI    = 13'b0_0_0_0_0_0_0_0_0_11_10;
    localparam logic [12:0] C_RST    = 13'b0_0_0_0_0_0_0_0_0_00_01;
    localparam logic [12:0] C_RSTMR  = 13'b0_0_0_1_0_0_0_0_0_00_00;
    localparam logic [12:0] C_ZERO   = 13'b0;

    typedef struct packed {
        logic [12:0] ctrl;
        logic        alu_chk;
        logic [31:0] alu_exp;
        logic        pcl_chk;
        logic        pcl_exp;
        logic        ill_exp;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];
    int    total = 0;
    int    bad   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t  e;
            string t;
            logic [12:0] got_ctrl;
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            got_ctrl = {bus.pc_write, bus.pc_write_cond, bus.pc_source, bus.lorD,
                        bus.memory_read, bus.memory_write, bus.memory_to_reg,
                        bus.ir_write, bus.reg_write, bus.alu_src_a, bus.alu_src_b};
            check_val({t, "_ctrl"}, {19'd0, got_ctrl}, {19'd0, e.ctrl});
            if (e.alu_chk) begin
                check_val({t, "_alu"}, bus.alu_result, e.alu_exp);
                check_val({t, "_zero"}, {31'd0, bus.zero}, {31'd0, e.alu_exp == 32'd0});
            end
            if (e.pcl_chk) check_val({t, "_pcload"}, {31'd0, bus.pc_load}, {31'd0, e.pcl_exp});
`ifdef ILLEGAL_OPCODE_EN
            check_val({t, "_illegal"}, {31'd0, bus.illegal_instruction}, {31'd0, e.ill_exp});
`endif
            $display("cycle %s ctrl=%013b alu=0x%08h pc_load=%0b", t, got_ctrl, bus.alu_result, bus.pc_load);
        end
    end

    task automatic cyc(input string tag, input logic [12:0] c, input logic [31:0] a, input logic [31:0] b,
                       input bit ac, input logic [31:0] ae, input bit pc, input bit pe, input bit ie);
        exp_t e;
        bus.alu_in_a = a;
        bus.alu_in_b = b;
        e.ctrl = c; e.alu_chk = ac; e.alu_exp = ae; e.pcl_chk = pc; e.pcl_exp = pe; e.ill_exp = ie;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
    endtask

    task automatic fetch_decode(input string tag, input logic [31:0] instr);
        bus.instruction = instr;
        cyc({tag, "_fetch"}, C_FETCH, 32'h100, 32'd4, 1'b1, 32'h104, 1'b1, 1'b1, 1'b0);
        cyc({tag, "_decode"}, C_DEC, 32'h40, 32'h8, 1'b1, 32'h48, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic alu_instr(input string tag, input logic [31:0] instr, input logic [12:0] c,
                             input logic [31:0] a, input logic [31:0] b, input logic [31:0] r);
        fetch_decode(tag, instr);
        cyc({tag, "_ex"}, c, a, b, 1'b1, r, 1'b0, 1'b0, 1'b0);
        cyc({tag, "_wb"}, C_WB, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic branch(input string tag, input logic [31:0] instr, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] r, input bit taken);
        fetch_decode(tag, instr);
        cyc({tag, "_br"}, C_BR, a, b, 1'b1, r, 1'b1, taken, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        reset = 1'b1;
        bus.instruction = 32'd0;
        bus.alu_in_a = 32'd0;
        bus.alu_in_b = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        cyc("reset", C_RST, 32'd0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
        reset = 1'b0;

        alu_instr("add",  32'h00208033, C_EXR, 32'd5, 32'd7, 32'd12);
        alu_instr("sub",  32'h40208033, C_EXR, 32'd5, 32'd7, 32'hFFFF_FFFE);
        alu_instr("addi", 32'h40008093, C_EXI, 32'd5, 32'd7, 32'd12);
        alu_instr("srai", 32'h4040D093, C_EXI, 32'h8000_0000, 32'd4, 32'hF800_0000);
        alu_instr("srli", 32'h0040D093, C_EXI, 32'h8000_0000, 32'd4, 32'h0800_0000);
        alu_instr("slt",  32'h0020A033, C_EXR, 32'hFFFF_FFFF, 32'd1, 32'd1);
        alu_instr("sltu", 32'h0020B033, C_EXR, 32'hFFFF_FFFF, 32'd1, 32'd0);
        alu_instr("xor",  32'h0020C033, C_EXR, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0);

        branch("bne_eq", 32'h00209463, 32'd3, 32'd3, 32'd1, 1'b0);
        branch("bne_ne", 32'h00209463, 32'd3, 32'd4, 32'd0, 1'b1);
        branch("beq_eq", 32'h00208463, 32'd3, 32'd3, 32'd0, 1'b1);
        branch("blt",    32'h0020C463, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1);
        branch("bgeu",   32'h0020F463, 32'd1, 32'd2, 32'd1, 1'b0);

        fetch_decode("load", 32'h0000A083);
        cyc("load_addr", C_EXI, 32'h1000, 32'h8, 1'b1, 32'h1008, 1'b0, 1'b0, 1'b0);
        cyc("load_read", C_MRD, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        cyc("load_wb",   C_MWB, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);

        fetch_decode("store", 32'h0020A023);
        cyc("store_addr",  C_EXI, 32'h2000, 32'h4, 1'b1, 32'h2004, 1'b0, 1'b0, 1'b0);
        cyc("store_write", C_MWR, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);

        fetch_decode("jal", 32'h008000EF);
        cyc("jal_jump", C_JAL, 32'h100, 32'd4, 1'b1, 32'h104, 1'b1, 1'b1, 1'b0);
        cyc("jal_wb",   C_WB,  32'd0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);

        fetch_decode("jalr", 32'h000080E7);
        cyc("jalr_jump", C_JALR, 32'h201, 32'h10, 1'b1, 32'h210, 1'b1, 1'b1, 1'b0);
        cyc("jalr_link", C_LINK, 32'h300, 32'd4, 1'b1, 32'h304, 1'b0, 1'b0, 1'b0);
        cyc("jalr_wb",   C_WB,   32'd0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);

        alu_instr("lui",   32'h123450B7, C_LUI, 32'd0, 32'h1234_5000, 32'h1234_5000);
        alu_instr("auipc", 32'h12345097, C_DEC, 32'h400, 32'h1234_5000, 32'h1234_5400);

        fetch_decode("ldrst", 32'h0000A083);
        cyc("ldrst_addr", C_EXI, 32'h10, 32'h4, 1'b1, 32'h14, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        cyc("ldrst_read", C_RSTMR, 32'd0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
        reset = 1'b0;

        fetch_decode("fence", 32'h0000000F);

        fetch_decode("illegal", 32'h0000007F);
`ifdef ILLEGAL_OPCODE_EN
        for (int i = 0; i < 3; i++)
            cyc("illegal_halt", C_ZERO, 32'd1, 32'd1, 1'b0, 32'd0, 1'b1, 1'b0, 1'b1);
        reset = 1'b1;
        cyc("illegal_rst", C_ZERO, 32'd0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b1);
        reset = 1'b0;
`endif
        alu_instr("after", 32'h00208033, C_EXR, 32'd20, 32'd22, 32'd42);

        for (int i = 0; i < 4 && exp_q.size() != 0; i++) @(negedge clk);
        check_val("drain", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/multicycle_ctrl_alu.md
Name: multicycle_ctrl_alu

Overview:
Control and execute slice of the multicycle RV32I core. It contains three parts:
- a Moore FSM that sequences fetch, decode, execute, memory and writeback;
- an ALU-operation decoder;
- a 32-bit combinational ALU.
Operand muxes, PC, register file, IR and pipeline latches sit outside this block and are steered by its select/enable outputs.

Parameters:
none

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
instruction  in  32  current IR contents (opcode [6:0], func3 [14:12], func7 [31:25])
alu_in_a  in  32  ALU operand A (from external A mux)
alu_in_b  in  32  ALU operand B (from external B mux)
alu_result  out  32  combinational ALU result
zero  out  1  alu_result == 0
pc_write  out  1  unconditional PC load
pc_write_cond  out  1  PC load qualified by zero
pc_load  out  1  pc_write | (pc_write_cond & zero)
pc_source  out  1  0 = alu_result, 1 = latched ALU output register
lorD  out  1  memory address select: 0 = PC, 1 = ALU output register
memory_read  out  1  memory read strobe
memory_write  out  1  memory write strobe
memory_to_reg  out  1  writeback select: 0 = ALU register, 1 = memory data register
ir_write  out  1  latch IR and pc_old
reg_write  out  1  register file write enable
alu_src_a  out  2  A select: 00 PC, 01 rs1, 10 pc_old, 11 zero
alu_src_b  out  2  B select: 00 rs2, 01 constant 4, 10 immediate

Behaviour:
- All control outputs decode from the state register only (Moore); pc_load is the one output that also depends on zero.
- Any control output not listed for a state is 0.
- Reset: state <= FETCH on a clock edge where reset=1. While reset=1, force pc_write, pc_write_cond, ir_write, reg_write, memory_read and memory_write to 0.

State encodings (4-bit) and actions:
- FETCH 0: memory_read, lorD=0, ir_write, src_a=00, src_b=01, ADD, pc_source=0, pc_write -> DECODE.
- DECODE 1: src_a=10, src_b=10, ADD (pre-computes branch/JAL target). Next state by opcode:
  - 0110011 -> EXEC_R
  - 0010011 -> EXEC_I
  - 0000011 / 0100011 -> MEM_ADDR
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - 1100111 -> JALR
  - 0110111 -> LUI
  - 0010111 -> AUIPC
  - 0001111 / 1110011 -> FETCH (NOP)
  - other opcodes: see Optional Feature.
- EXEC_R 2: src_a=01, src_b=00, func decode with is_immediate=0 -> ALU_WB.
- EXEC_I 3: src_a=01, src_b=10, func decode with is_immediate=1 -> ALU_WB.
- ALU_WB 4: reg_write, memory_to_reg=0 -> FETCH.
- MEM_ADDR 5: src_a=01, src_b=10, ADD. Load -> MEM_READ; store -> MEM_WRITE.
- MEM_READ 6: lorD=1, memory_read -> MEM_WB.
- MEM_WB 7: reg_write, memory_to_reg=1 -> FETCH.
- MEM_WRITE 8: lorD=1, memory_write -> FETCH.
- BRANCH 9: src_a=01, src_b=00, branch decode, pc_write_cond, pc_source=1 -> FETCH.
- JAL 10: src_a=10, src_b=01, ADD, pc_write, pc_source=1 -> ALU_WB.
- JALR 11: src_a=01, src_b=10, ADD_CLR0, pc_write, pc_source=0 -> LINK.
- LINK 12: src_a=10, src_b=01, ADD -> ALU_WB.
- LUI 13: src_a=11, src_b=10, ADD -> ALU_WB.
- AUIPC 14: src_a=10, src_b=10, ADD -> ALU_WB.
- HALT 15: all outputs 0; stays until reset.

Cycle counts: R/I/LUI/AUIPC 4, load 5, store 4, branch 3, JAL 4, JALR 5.

ALU op codes (4-bit):
- AND 0000, OR 0001, ADD 0010, XOR 0100, SLL 0101, SRL 0110, SRA 0111
- SLT 1000, SLTU 1001, SUB 1010, SEQ 1011, SGE 1100, SGEU 1101, ADD_CLR0 1110 (sum with bit0 = 0)
- 0011 and 1111 -> result 0.
- Shifts use alu_in_b[4:0]. Compare ops return 32-bit 0 or 1; SLT/SGE signed, SLTU/SGEU unsigned.

Func decode (EXEC_R / EXEC_I), by func3:
- 000: SUB if !is_immediate & func7[5], else ADD
- 001: SLL
- 010: SLT
- 011: SLTU
- 100: XOR
- 101: SRA if func7[5], else SRL
- 110: OR
- 111: AND

Branch decode: ALU result is 0 exactly when the branch is taken. By func3:
- 000 (BEQ): SUB
- 001 (BNE): SEQ
- 100 (BLT): SGE
- 101 (BGE): SLT
- 110 (BLTU): SGEU
- 111 (BGEU): SLTU
- 010 / 011: SUB

Optional Feature:
ILLEGAL_OPCODE_EN.
- Defined: adds output illegal_instruction (1 bit). An unknown opcode in DECODE goes to HALT; illegal_instruction=1 only in HALT.
- Undefined: no port; unknown opcodes go DECODE -> FETCH (NOP) and HALT is unreachable.

Test Plan:
- Reset, then instruction=0x00208033 (ADD): states FETCH, DECODE, EXEC_R, ALU_WB, FETCH. ir_write=1 and pc_write=1 only in FETCH; reg_write=1 only in ALU_WB. With a=5, b=7 in EXEC_R, alu_result=12.
- SUB 0x40208033, a=5, b=7 -> 0xFFFFFFFE, zero=0. ADDI with imm[11:5]=0100000, a=5, b=7 -> 12 (no SUB).
- SRAI 0x4040D093 with a=0x80000000, b=4 -> 0xF8000000. SRLI 0x0040D093 -> 0x08000000.
- BNE 0x00209463 in BRANCH: a=b=3 -> pc_load=0; a=3, b=4 -> pc_load=1, pc_source=1.
- Load 0x0000A083: 5 cycles; MEM_READ has memory_read=1, lorD=1; MEM_WB has memory_to_reg=1, reg_write=1. Store 0x0020A023: MEM_WRITE has memory_write=1, lorD=1, then FETCH.
- Reset asserted during MEM_READ: strobes 0 that cycle; FETCH on next edge. Opcode 0x7F with ILLEGAL_OPCODE_EN: HALT, illegal_instruction=1 until reset. Without the macro: FETCH.
